// File: rtl/sha256_pkg.sv
// Shared constants and padder state encoding for the SHA-256 front end.
// Block geometry and the fixed length-field word positions live here.
package sha256_pkg;

  localparam int WORDS_PER_BLK = 16;
  localparam int IDX_W = $clog2(WORDS_PER_BLK);

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LEN_HI_IDX = idx_t'(14);
  localparam idx_t LEN_LO_IDX = idx_t'(15);
  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD1,
    ST_ZERO,
    ST_LENH,
    ST_LENL
  } pad_state_t;

endpackage

// File: rtl/sha256_pad_word.sv
// Tail-word formatter: keeps the first k bytes, puts 0x80 at byte k,
// clears the rest. Byte 0 is the most significant byte.
module sha256_pad_word (
  input  logic [31:0] data_i,
  input  logic [1:0]  k_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < int'(k_i)) begin
        word_o[31-8*b -: 8] = data_i[31-8*b -: 8];
      end else if (b == int'(k_i)) begin
        word_o[31-8*b -: 8] = 8'h80;
      end
    end
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: streams message words in, emits padded
// 512-bit blocks as 16 words through a single registered output slot.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] msg_data_in,
  input  logic [2:0]  msg_bytes_in,
  input  logic        msg_last_in,
  input  logic        msg_valid_in,
  output logic        msg_ready_out,
  output logic [31:0] w_data_out,
  output logic        w_valid_out,
  input  logic        w_ready_in,
  output logic        blk_first_out,
  output logic        blk_last_out,
  output logic        msg_done_out
);

  pad_state_t state_q, state_d;
  idx_t idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic vld_q, vld_d;
  logic [31:0] data_q, data_d;
  logic first_q, first_d;
  logic last_q, last_d;
  logic done_q, done_d;

  logic load_en;
  logic accept;
  logic load;
  logic done_w;
  logic [31:0] word;
  logic [31:0] pad_word;
  logic [63:0] len64;
  logic pre_len;

  sha256_pad_word u_pad (
    .data_i (msg_data_in),
    .k_i    (msg_bytes_in[1:0]),
    .word_o (pad_word)
  );

  assign load_en = !vld_q || w_ready_in;
  assign msg_ready_out = rst_n && load_en &&
    (state_q == ST_IDLE || state_q == ST_DATA);
  assign accept = msg_valid_in && msg_ready_out;
  assign len64 = 64'(len_q);
  // Pad word landing at idx 13 leaves no room for zero fill.
  assign pre_len = (idx_q == LEN_HI_IDX - idx_t'(1));

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    vld_d = vld_q && !w_ready_in;
    data_d = data_q;
    first_d = first_q;
    last_d = last_q;
    done_d = done_q;
    load = 1'b0;
    done_w = 1'b0;
    word = '0;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          load = 1'b1;
          if (!msg_last_in || msg_bytes_in[2]) begin
            word = msg_data_in;
            len_d = len_q + LEN_W'(32);
            state_d = msg_last_in ? ST_PAD1 : ST_DATA;
          end else begin
            word = pad_word;
            len_d = len_q + LEN_W'({msg_bytes_in[1:0], 3'b000});
            state_d = pre_len ? ST_LENH : ST_ZERO;
          end
        end
      end
      ST_PAD1: begin
        if (load_en) begin
          load = 1'b1;
          word = PAD_WORD;
          state_d = pre_len ? ST_LENH : ST_ZERO;
        end
      end
      ST_ZERO: begin
        if (load_en) begin
          load = 1'b1;
          state_d = pre_len ? ST_LENH : ST_ZERO;
        end
      end
      ST_LENH: begin
        if (load_en) begin
          load = 1'b1;
          word = len64[63:32];
          state_d = ST_LENL;
        end
      end
      ST_LENL: begin
        if (load_en) begin
          load = 1'b1;
          word = len64[31:0];
          done_w = 1'b1;
          len_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      vld_d = 1'b1;
      data_d = word;
      first_d = (idx_q == '0);
      last_d = (idx_q == LEN_LO_IDX);
      done_d = done_w;
      idx_d = idx_q + idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      len_q <= '0;
      vld_q <= 1'b0;
      data_q <= '0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      vld_q <= vld_d;
      data_q <= data_d;
      first_q <= first_d;
      last_q <= last_d;
      done_q <= done_d;
    end
  end

  assign w_valid_out = vld_q;
  assign w_data_out = data_q;
  assign blk_first_out = first_q;
  assign blk_last_out = last_q;
  assign msg_done_out = done_q;

endmodule
